onehot_demux_reg: RTL
=====================

Name: onehot_demux_reg

Overview:
Inverse of the one-hot mux. A single valid/ready input stream carries a one-hot destination select. Each beat is steered into a one-entry output register on the selected lane, and each lane then drains independently through its own valid/ready handshake. Used at router/NoC egress to fan one source out to N consumers with registered outputs and per-lane backpressure.

Parameters:
OutputWidth, 8, number of output lanes (≥2); also the width of the one-hot select.
DataWidth, 8, payload bits per beat.
CntWidth, 8, width of the saturating drop counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
valid_i  input  1  input beat valid.
ready_o  output  1  input beat accepted this cycle when valid_i & ready_o.
sel_i  input  OutputWidth  one-hot destination lane for the beat; qualified by valid_i.
data_i  input  DataWidth  input payload.
valid_o  output  OutputWidth  per-lane output valid (registered).
ready_i  input  OutputWidth  per-lane consumer ready.
data_o  output  OutputWidth x DataWidth  per-lane payload register, packed [OutputWidth-1:0][DataWidth-1:0].
drop_cnt_o  output  CntWidth  saturating count of beats dropped for illegal select.
err_o  output  1  sticky flag: any illegal select seen since reset.

Behaviour:
- Reset (async, rst=1): valid_o=0, data_o=0, drop_cnt_o=0, err_o=0 immediately, independent of clk. Deassertion is synchronous in effect: the first capture happens on the first rising edge with rst=0.
- Legal select: sel_i has exactly one bit set (popcount==1). Illegal select: zero bits or more than one bit set.
- Lane k is free when: ~valid_o[k] | ready_i[k].
- ready_o is combinational:
  - legal select: the free term of the selected lane;
  - illegal select: 1, so the beat is always consumed and dropped.
  - ready_o must not depend on valid_i.
- Accept: valid_i & ready_o.
  - Legal select: data_o[k] <= data_i and valid_o[k] <= 1 at the next edge. Latency from input to output is exactly 1 cycle.
  - Illegal select: no lane changes; drop_cnt_o increments, saturating at 2^CntWidth-1; err_o <= 1.
- Drain: valid_o[k] & ready_i[k] clears valid_o[k] at the next edge, unless the same lane is reloaded in that cycle.
- Same lane drained and loaded in one cycle: valid_o[k] stays 1 and data_o[k] takes the new data. No bubble; full throughput of 1 beat/cycle per lane.
- Selected lane full and its ready_i low: ready_o=0; the input must hold. The other lanes keep draining unaffected.
- Different lanes: loading lane a while lanes b,c drain in the same cycle is legal and all take effect.
- data_o[k] holds its value while valid_o[k]=0. It changes only on load or reset.
- valid_i=0: sel_i and data_i are ignored. There is no drop counting and no state change.
- No combinational path from data_i to data_o. Output-side paths: ready_i→ready_o and sel_i→ready_o only.
- Assertion (sim only): while valid_o[k] & ~ready_i[k], data_o[k] must be stable.

Test Plan:
- Reset/idle: assert rst mid-run with lane 3 holding 0xA5 → valid_o=0, data_o=0, drop_cnt_o=0, err_o=0 without a clock edge. Release, hold valid_i=0 for 10 cycles → no change.
- Single route: OutputWidth=8, sel_i=8'b0000_0100, data_i=0x3C, ready_i=0 → ready_o=1, next cycle valid_o=8'h04 and data_o[2]=0x3C. Second beat to lane 2 → ready_o=0 until ready_i[2]=1.
- Back-to-back same lane: ready_i[5]=1, stream 0x01..0x10 to sel=8'h20 on consecutive cycles → ready_o=1 every cycle; data_o[5] shows each value 1 cycle later; 16 beats in 16 cycles.
- Independent backpressure: lane 0 full with ready_i[0]=0; beats to lanes 1 and 7 → accepted and delivered; lane 0 holds its data unchanged.
- Illegal select: send sel=0x00 then sel=0x03 (valid_i=1) → ready_o=1 both cycles; no valid_o change; drop_cnt_o=2; err_o=1. With CntWidth=2, send 5 illegal beats → drop_cnt_o saturates at 3.
- Drain/load race: lane 4 valid with 0x11, same cycle ready_i[4]=1 and new beat 0x22 to lane 4 → next cycle valid_o[4]=1, data_o[4]=0x22; 0x11 observed consumed exactly once.

Source files
------------

// File: rtl/onehot_demux_reg.sv
// One-hot demultiplexer with one registered entry per output lane.
// Each output lane drains through its own valid/ready handshake. Illegal selects are dropped and counted.

module onehot_demux_reg_lane #(
  parameter int DataWidth = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [DataWidth-1:0] i_data,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [DataWidth-1:0] o_data
);
  logic                 r_valid;
  logic [DataWidth-1:0] r_data;

  // A load takes priority over a drain, so a full lane can be drained and refilled in one cycle with no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (r_valid && !i_ready) |=> $stable(r_data));
endmodule

module onehot_demux_reg #(
  parameter int OutputWidth = 8,
  parameter int DataWidth   = 8,
  parameter int CntWidth    = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  valid_i,
  output logic                                  ready_o,
  input  logic [OutputWidth-1:0]                sel_i,
  input  logic [DataWidth-1:0]                  data_i,
  output logic [OutputWidth-1:0]                valid_o,
  input  logic [OutputWidth-1:0]                ready_i,
  output logic [OutputWidth-1:0][DataWidth-1:0] data_o,
  output logic [CntWidth-1:0]                   drop_cnt_o,
  output logic                                  err_o
);
  logic                   w_legal;
  logic                   w_accept;
  logic [OutputWidth-1:0] w_free;
  logic [OutputWidth-1:0] w_load;
  logic [CntWidth-1:0]    r_drop_cnt;
  logic                   r_err;

  // A select is legal when exactly one bit is set: it is non-zero, and clearing its lowest set bit leaves zero.
  assign w_legal  = (sel_i != '0) &&
                    ((sel_i & (sel_i - OutputWidth'(1))) == '0);
  assign w_free   = ~valid_o | ready_i;
  assign ready_o  = w_legal ? |(sel_i & w_free) : 1'b1;
  assign w_accept = valid_i & ready_o;
  assign w_load   = (w_accept && w_legal) ? sel_i : '0;

  for (genvar g = 0; g < OutputWidth; g++) begin : g_lane
    onehot_demux_reg_lane #(.DataWidth(DataWidth)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load[g]),
      .i_data  (data_i),
      .i_ready (ready_i[g]),
      .o_valid (valid_o[g]),
      .o_data  (data_o[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
      r_err      <= 1'b0;
    end else if (w_accept && !w_legal) begin
      r_err <= 1'b1;
      if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CntWidth'(1);
    end
  end

  assign drop_cnt_o = r_drop_cnt;
  assign err_o      = r_err;
endmodule
